floo_mcast_rsp_join: RTL and testbench
======================================

Name: floo_mcast_rsp_join

Overview:
- Join side of the multicast fork in the router. The fork logic converts a destination mask into a set of output routes and forwards the request to each of them.
- This block takes each forked transaction's route-select vector and collects exactly one write response per selected route.
- It merges those responses into a single response returned toward the source.
- It sits in the router response path, one instance per multicast-capable input port.

Parameters:
- NumRoutes, 5, number of router routes (Eject/North/East/South/West).
- MaxOutstanding, 4, depth of the expected-route-mask FIFO. Must be ≥1.
- IdWidth, 4, width of the response transaction ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- exp_valid_i  in  1  expected route mask valid (from the fork).
- exp_ready_o  out  1  mask FIFO can accept.
- exp_sel_i  in  NumRoutes  route-select vector of the forked request.
- rsp_valid_i  in  NumRoutes  per-route response valid.
- rsp_ready_o  out  NumRoutes  per-route response ready.
- rsp_id_i  in  NumRoutes×IdWidth  per-route response ID.
- rsp_resp_i  in  NumRoutes×2  per-route BRESP.
- mrg_valid_o  out  1  merged response valid.
- mrg_ready_i  in  1  merged response accepted.
- mrg_id_o  out  IdWidth  merged ID.
- mrg_resp_o  out  2  merged BRESP.
- busy_o  out  1  FIFO non-empty or output pending.

Behaviour:

Reset (rst_ni low, asynchronous):
- FIFO empty; arrived bits 0; state IDLE.
- exp_ready_o=1 after reset release; rsp_ready_o=0; mrg_valid_o=0; mrg_id_o=0; mrg_resp_o=0; busy_o=0.
- Reset mid-transaction discards all collected state. No partial response is emitted.

Mask FIFO:
- Push when exp_valid_i & exp_ready_o.
- exp_ready_o = !full. A pop in the same cycle does not free a slot for a same-cycle push.
- An all-zero exp_sel_i is accepted and discarded: not stored, no merged response.

State machine:
- IDLE: FIFO empty.
  - Go to COLLECT the cycle after the first push.
  - The head mask is registered; no combinational push-to-collect path.
- COLLECT:
  - rsp_ready_o[r] = head_mask[r] & !arrived[r].
  - On rsp_valid_i[r] & rsp_ready_o[r]: set arrived[r]; fold rsp_resp_i[r] into the merged resp register.
  - mrg_id_o is captured from the lowest-index accepted route.
  - Multiple routes may handshake in the same cycle. All are folded at once.
  - When (arrived | this cycle's accepts) == head_mask, go to SEND.
- SEND:
  - mrg_valid_o=1 and rsp_ready_o=0.
  - mrg_valid_o rises the cycle after the last response handshake (1-cycle latency).
  - On mrg_ready_i: pop FIFO, clear arrived and merged registers.
  - Go to COLLECT if the FIFO still holds an entry, else IDLE.
  - mrg_valid_o stays high, with stable mrg_id_o and mrg_resp_o, until mrg_ready_i.

Response merge (severity order):
- DECERR(11) if any DECERR.
- Else SLVERR(10) if any SLVERR.
- Else OKAY(00) if any OKAY.
- Else EXOKAY(01), which requires all responses to be EXOKAY.

Boundary conditions:
- Responses on unselected or already-arrived routes are never accepted. They are held, not dropped, so they stay available for the next mask.
- ID mismatch across routes is not checked. The lowest-index accepted route's ID wins.
- Full FIFO with simultaneous push and pop: push is refused that cycle.
- Single-bit mask: degenerates to a registered pass-through with 1-cycle latency.

Decomposition:
- floo_pkg provides the route_direction_e route indices and the AXI resp encodings (RespOkay, RespExOkay, RespSlvErr, RespDecErr).
- A severity-merge function lives in floo_pkg for reuse by read-response joins.
- One sub-module, the expected-mask FIFO: common_cells fifo_v3, DATA_WIDTH=NumRoutes, DEPTH=MaxOutstanding.
- The FSM, arrived register and merge register live in the top module.

Test Plan:
1. Reset, then push exp_sel=5'b10100. Drive routes 2 and 4 OKAY, ID 3, in different cycles -> single merged valid one cycle after the second handshake, resp=00, id=3. Route 0 ready stays 0 throughout.
2. Push 5'b00111. Routes 0, 1, 2 valid in the same cycle, route 1 SLVERR -> all three accepted that cycle; merged resp=10 on the next cycle.
3. Push 5'b00011. Route 3 valid early, then routes 0 and 1 -> route 3 never accepted; merged response emitted; route 3 still pending for the next mask 5'b01000, which produces a second merged response.
4. Hold mrg_ready_i=0 for 5 cycles while pushing 4 masks -> exp_ready_o drops after MaxOutstanding entries; mrg outputs stay stable; draining releases them in order.
5. Push 5'b00000 followed by 5'b00001 -> only one merged response, for route 0.
6. Assert rst_ni low after 1 of 2 expected responses -> all outputs return to reset values immediately; no merged response after release.

Source files
------------

// File: rtl/floo_pkg.sv
// Shared router definitions: route indices, AXI response codes and the
// response severity merge used by the multicast joins.
package floo_pkg;

    typedef enum logic [2:0] {
        Eject = 3'd0,
        North = 3'd1,
        East  = 3'd2,
        South = 3'd3,
        West  = 3'd4
    } route_direction_e;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RespOkay   = 2'b00;
    localparam axi_resp_t RespExOkay = 2'b01;
    localparam axi_resp_t RespSlvErr = 2'b10;
    localparam axi_resp_t RespDecErr = 2'b11;

    // Severity order DECERR > SLVERR > OKAY > EXOKAY; EXOKAY is the identity,
    // so a fold seeded with EXOKAY stays EXOKAY only if every input was EXOKAY.
    function automatic axi_resp_t resp_merge(input axi_resp_t a, input axi_resp_t b);
        if (a == RespDecErr || b == RespDecErr) return RespDecErr;
        if (a == RespSlvErr || b == RespSlvErr) return RespSlvErr;
        if (a == RespOkay   || b == RespOkay)   return RespOkay;
        return RespExOkay;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the expected route masks. A push into a full
// FIFO is ignored even if a pop happens in the same cycle.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    usage_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == AddrW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == AddrW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/floo_mcast_rsp_join.sv
// Multicast write-response join: collects one B response per route selected
// by the forked request and returns a single severity-merged response.
module floo_mcast_rsp_join
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes      = 5,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         exp_valid_i,
    output logic                         exp_ready_o,
    input  logic [NumRoutes-1:0]         exp_sel_i,
    input  logic [NumRoutes-1:0]         rsp_valid_i,
    output logic [NumRoutes-1:0]         rsp_ready_o,
    input  logic [NumRoutes*IdWidth-1:0] rsp_id_i,
    input  logic [NumRoutes*2-1:0]       rsp_resp_i,
    output logic                         mrg_valid_o,
    input  logic                         mrg_ready_i,
    output logic [IdWidth-1:0]           mrg_id_o,
    output logic [1:0]                   mrg_resp_o,
    output logic                         busy_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StSend    = 2'd2;

    localparam int unsigned CntW = $clog2(MaxOutstanding+1);

    logic [1:0]           state_q, state_d;
    logic [NumRoutes-1:0] arrived_q, arrived_d;
    axi_resp_t            resp_q, resp_d;
    logic [IdWidth-1:0]   id_q, id_d;

    logic                 fifo_full, fifo_empty;
    logic [CntW-1:0]      fifo_usage;
    logic [NumRoutes-1:0] head_mask;
    logic                 push, pop;
    logic [NumRoutes-1:0] acc;
    logic                 lower_arrived, id_taken;

    // All-zero masks complete the handshake but are never stored.
    assign exp_ready_o = ~fifo_full;
    assign push        = exp_valid_i & exp_ready_o & (|exp_sel_i);
    assign pop         = (state_q == StSend) & mrg_ready_i;

    assign rsp_ready_o = (state_q == StCollect) ? (head_mask & ~arrived_q) : '0;
    assign acc         = rsp_valid_i & rsp_ready_o;

    assign mrg_valid_o = (state_q == StSend);
    assign mrg_id_o    = (state_q == StSend) ? id_q : '0;
    assign mrg_resp_o  = (state_q == StSend) ? resp_q : '0;
    assign busy_o      = ~fifo_empty | (state_q != StIdle);

    fifo_v3 #(
        .DATA_WIDTH (NumRoutes),
        .DEPTH      (MaxOutstanding)
    ) i_mask_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (exp_sel_i),
        .pop_i   (pop),
        .data_o  (head_mask),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage)
    );

    // Next-state, arrival tracking and response/ID folding.
    always_comb begin
        state_d       = state_q;
        arrived_d     = arrived_q;
        resp_d        = resp_q;
        id_d          = id_q;
        lower_arrived = 1'b0;
        id_taken      = 1'b0;
        case (state_q)
            StIdle: begin
                if (push || !fifo_empty) state_d = StCollect;
            end
            StCollect: begin
                arrived_d = arrived_q | acc;
                // The ID follows the lowest-index route of the whole
                // transaction, so a new accept only claims it when no
                // lower-index route has already arrived.
                for (int unsigned r = 0; r < NumRoutes; r++) begin
                    if (acc[r]) begin
                        resp_d = resp_merge(resp_d, rsp_resp_i[2*r +: 2]);
                        if (!lower_arrived && !id_taken) begin
                            id_d     = rsp_id_i[r*IdWidth +: IdWidth];
                            id_taken = 1'b1;
                        end
                    end
                    lower_arrived = lower_arrived | arrived_q[r];
                end
                if ((arrived_q | acc) == head_mask) state_d = StSend;
            end
            StSend: begin
                if (mrg_ready_i) begin
                    arrived_d = '0;
                    resp_d    = RespExOkay;
                    id_d      = '0;
                    state_d   = (fifo_usage > CntW'(1) || push) ? StCollect : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and merge registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            arrived_q <= '0;
            resp_q    <= RespExOkay;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            arrived_q <= arrived_d;
            resp_q    <= resp_d;
            id_q      <= id_d;
        end
    end

endmodule

// File: tb/tb_floo_mcast_rsp_join.sv
// Scoreboard bench for floo_mcast_rsp_join: directed stimulus pushes expected
// merged responses, a monitor compares every merged-response handshake.
module tb_floo_mcast_rsp_join;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        exp_valid_i = 1'b0;
    logic        exp_ready_o;
    logic [4:0]  exp_sel_i = '0;
    logic [4:0]  rsp_valid_i = '0;
    logic [4:0]  rsp_ready_o;
    logic [19:0] rsp_id_i = '0;
    logic [9:0]  rsp_resp_i = '0;
    logic        mrg_valid_o;
    logic        mrg_ready_i = 1'b1;
    logic [3:0]  mrg_id_o;
    logic [1:0]  mrg_resp_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] sb [$];

    floo_mcast_rsp_join #(
        .NumRoutes      (5),
        .MaxOutstanding (4),
        .IdWidth        (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .exp_valid_i (exp_valid_i),
        .exp_ready_o (exp_ready_o),
        .exp_sel_i   (exp_sel_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_id_i    (rsp_id_i),
        .rsp_resp_i  (rsp_resp_i),
        .mrg_valid_o (mrg_valid_o),
        .mrg_ready_i (mrg_ready_i),
        .mrg_id_o    (mrg_id_o),
        .mrg_resp_o  (mrg_resp_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Merged-response monitor: every handshake must match the next expectation.
    always @(negedge clk_i) begin
        if (rst_ni && mrg_valid_o && mrg_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mrg: got id=%0d resp=%0b with nothing expected", mrg_id_o, mrg_resp_o);
            end else begin
                chk("mrg_id_resp", {26'd0, mrg_id_o, mrg_resp_o}, {26'd0, sb.pop_front()});
            end
        end
    end

    task automatic set_route(input int r, input logic [3:0] id, input logic [1:0] resp);
        rsp_id_i[r*4 +: 4]   = id;
        rsp_resp_i[r*2 +: 2] = resp;
    endtask

    task automatic push_mask(input logic [4:0] sel);
        int n = 0;
        exp_valid_i = 1'b1;
        exp_sel_i   = sel;
        @(negedge clk_i);
        while (!exp_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!exp_ready_o) fail_timeout("push_mask");
        @(posedge clk_i); #1;
        exp_valid_i = 1'b0;
    endtask

    // Raise valid on the wanted routes and wait until each is accepted;
    // ready must never appear outside the allowed set.
    task automatic drive_rsp(input logic [4:0] want, input logic [4:0] allowed, output int ncyc);
        logic [4:0] left, acc;
        left = want;
        rsp_valid_i = rsp_valid_i | want;
        ncyc = 0;
        while (left != 0 && ncyc < 20) begin
            @(negedge clk_i);
            chk("ready_allowed", {27'd0, rsp_ready_o & ~allowed}, 32'd0);
            acc = rsp_valid_i & rsp_ready_o & left;
            @(posedge clk_i); #1;
            rsp_valid_i = rsp_valid_i & ~acc;
            left = left & ~acc;
            ncyc++;
        end
        if (left != 0) fail_timeout("drive_rsp");
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_i);
        while (busy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) fail_timeout("wait_idle");
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc;

        // Reset values
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_exp_ready", {31'd0, exp_ready_o}, 32'd1);
        chk("rst_rsp_ready", {27'd0, rsp_ready_o}, 32'd0);
        chk("rst_mrg_valid", {31'd0, mrg_valid_o}, 32'd0);
        chk("rst_mrg_id", {28'd0, mrg_id_o}, 32'd0);
        chk("rst_mrg_resp", {30'd0, mrg_resp_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i); #1;

        // 1: mask 10100, routes 2 and 4 in separate cycles
        push_mask(5'b10100);
        set_route(2, 4'd3, 2'b00);
        set_route(4, 4'd3, 2'b00);
        sb.push_back({4'd3, 2'b00});
        drive_rsp(5'b00100, 5'b10100, nc);
        chk("t1_no_early_valid", {31'd0, mrg_valid_o}, 32'd0);
        drive_rsp(5'b10000, 5'b10100, nc);
        chk("t1_latency", {31'd0, mrg_valid_o}, 32'd1);

        // 2: mask 00111, three routes together, route 1 SLVERR
        push_mask(5'b00111);
        set_route(0, 4'd5, 2'b00);
        set_route(1, 4'd6, 2'b10);
        set_route(2, 4'd7, 2'b00);
        sb.push_back({4'd5, 2'b10});
        drive_rsp(5'b00111, 5'b00111, nc);
        chk("t2_same_cycle", nc, 32'd1);
        chk("t2_latency", {31'd0, mrg_valid_o}, 32'd1);

        // 3: route 3 held while mask 00011 completes, then consumed by 01000
        set_route(3, 4'd9, 2'b10);
        rsp_valid_i[3] = 1'b1;
        push_mask(5'b00011);
        set_route(0, 4'd2, 2'b01);
        set_route(1, 4'd4, 2'b01);
        sb.push_back({4'd2, 2'b01});
        drive_rsp(5'b00011, 5'b00011, nc);
        chk("t3_route3_held", {31'd0, rsp_valid_i[3]}, 32'd1);
        sb.push_back({4'd9, 2'b10});
        push_mask(5'b01000);
        drive_rsp(5'b01000, 5'b01000, nc);
        wait_idle();

        // 4: back-pressure with a full mask FIFO
        mrg_ready_i = 1'b0;
        sb.push_back({4'd1, 2'b00});
        sb.push_back({4'd2, 2'b10});
        sb.push_back({4'd3, 2'b11});
        sb.push_back({4'd4, 2'b01});
        set_route(0, 4'd1, 2'b00);
        set_route(1, 4'd2, 2'b10);
        set_route(2, 4'd3, 2'b11);
        set_route(3, 4'd4, 2'b01);
        push_mask(5'b00001);
        drive_rsp(5'b00001, 5'b00001, nc);
        push_mask(5'b00010);
        push_mask(5'b00100);
        push_mask(5'b01000);
        exp_valid_i = 1'b1;
        exp_sel_i   = 5'b10000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t4_full", {31'd0, exp_ready_o}, 32'd0);
            chk("t4_hold", {26'd0, mrg_valid_o, mrg_id_o, mrg_resp_o}, {26'd0, 1'b1, 4'd1, 2'b00});
        end
        @(posedge clk_i); #1;
        mrg_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t4_full_with_pop", {31'd0, exp_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        exp_valid_i = 1'b0;
        drive_rsp(5'b00010, 5'b00010, nc);
        drive_rsp(5'b00100, 5'b00100, nc);
        drive_rsp(5'b01000, 5'b01000, nc);
        wait_idle();
        chk("t4_drained", sb.size(), 32'd0);

        // 5: zero mask is dropped, next mask handled normally
        push_mask(5'b00000);
        @(negedge clk_i);
        chk("t5_zero_not_stored", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        set_route(0, 4'd6, 2'b00);
        sb.push_back({4'd6, 2'b00});
        push_mask(5'b00001);
        drive_rsp(5'b00001, 5'b00001, nc);
        chk("t5_latency", {31'd0, mrg_valid_o}, 32'd1);
        wait_idle();

        // 6: reset after one of two responses
        push_mask(5'b00011);
        set_route(0, 4'd8, 2'b11);
        drive_rsp(5'b00001, 5'b00011, nc);
        rst_ni = 1'b0;
        #1;
        chk("t6_rsp_ready", {27'd0, rsp_ready_o}, 32'd0);
        chk("t6_mrg", {25'd0, mrg_valid_o, mrg_id_o, mrg_resp_o}, 32'd0);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_exp_ready", {31'd0, exp_ready_o}, 32'd1);
        @(posedge clk_i); #3;
        rst_ni = 1'b1;
        set_route(1, 4'd8, 2'b00);
        rsp_valid_i = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t6_idle_ready", {27'd0, rsp_ready_o}, 32'd0);
        end
        rsp_valid_i = '0;
        chk("t6_idle_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk_i);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
